// File: rtl/fft64_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fft64_ctrl_pkg
// Shared definitions for the USFFT64_2B sequencer:
//   state_t          sequencer FSM states (IDLE, ARM, STREAM, FLUSH)
//   FRAME_LEN        samples per FFT frame (64)
//   FRAME_AW         width of a sample/result index (6)
//   MAX_OUTSTANDING  frames that can be inside the core at once (3)
//   SHIFT_S*_LSB     bit offsets of the per-stage fields inside FFT_SHIFT
//   sat_dec2()       2-bit decrement that saturates at 0
// ---------------------------------------------------------------------------
package fft64_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARM    = 2'd1,
      STREAM = 2'd2,
      FLUSH  = 2'd3
   } state_t;

   localparam int FRAME_LEN       = 64;
   localparam int FRAME_AW        = 6;
   localparam int MAX_OUTSTANDING = 3;

   localparam int SHIFT_FIELD_W   = 2;
   localparam int SHIFT_S1_LSB    = 0;
   localparam int SHIFT_S2_LSB    = 2;

   function automatic logic [SHIFT_FIELD_W-1:0] sat_dec2(input logic [SHIFT_FIELD_W-1:0] v);
      sat_dec2 = (v == '0) ? v : v - 1'b1;
   endfunction

endpackage

// File: rtl/fft64_out_tracker.sv
// ---------------------------------------------------------------------------
// fft64_out_tracker
// Re-frames the FFT core's RDY/ADDR result stream into a qualified stream.
// A 64-cycle output window opens on the first ED cycle after RDY is seen
// with ED high; the window advances only on ED cycles.
//
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_ed           core enable (the core advances only when high)
//   i_rdy          core RDY
//   i_pend         a real frame is still owed by the core
//   i_ovf1/i_ovf2  core overflow flags
//   i_addr         core result address
//   o_vld          result valid this cycle (window open and ED)
//   o_addr         result index (0 outside a valid cycle)
//   o_sof/o_eof    first / last result of the frame
//   o_ovf          {OVF2, OVF1} captured at the last EOF
//   o_open         window is open (registered)
// ---------------------------------------------------------------------------
module fft64_out_tracker
   import fft64_ctrl_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_ed,
   input  logic                i_rdy,
   input  logic                i_pend,
   input  logic                i_ovf1,
   input  logic                i_ovf2,
   input  logic [FRAME_AW-1:0] i_addr,
   output logic                o_vld,
   output logic [FRAME_AW-1:0] o_addr,
   output logic                o_sof,
   output logic                o_eof,
   output logic [1:0]          o_ovf,
   output logic                o_open
);

   logic                r_open;
   logic [FRAME_AW-1:0] r_wcnt;
   logic [1:0]          r_ovf;

   logic w_vld;
   logic w_last;
   logic w_free;
   logic w_start;

   assign w_vld  = r_open & i_ed;
   assign w_last = (r_wcnt == FRAME_AW'(FRAME_LEN - 1));
   // The window may restart only when idle or on its own final cycle, so a
   // stray RDY mid-window cannot truncate a frame.
   assign w_free = ~r_open | w_last;
   // RDY produced by the zero-filled flush frames is ignored: a window opens
   // only while a real frame is still owed.
   assign w_start = i_ed & i_rdy & w_free & i_pend;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_open <= 1'b0;
         r_wcnt <= '0;
         r_ovf  <= 2'b00;
      end else begin
         if (w_vld && w_last) begin
            r_ovf <= {i_ovf2, i_ovf1};
         end
         if (w_start) begin
            r_open <= 1'b1;
            r_wcnt <= '0;
         end else if (w_vld) begin
            r_wcnt <= r_wcnt + 1'b1;
            if (w_last) begin
               r_open <= 1'b0;
            end
         end
      end
   end

   assign o_vld  = w_vld;
   assign o_addr = w_vld ? i_addr : '0;
   assign o_sof  = w_vld & (r_wcnt == '0);
   assign o_eof  = w_vld & w_last;
   assign o_ovf  = r_ovf;
   assign o_open = r_open;

endmodule

// File: rtl/fft64_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fft64_seq_ctrl
// Sequencer for the 64-point pipelined FFT core USFFT64_2B. Converts a
// valid/ready sample stream into the core's ED/START/DR/DI protocol, tracks
// frames in flight, drains the pipeline at session end and qualifies the
// core's result stream with VLD/ADDR/SOF/EOF/OVF.
//
// Parameters:
//   NB          sample width (matches the core's nb)
//   SHIFT_INIT  SHIFT code loaded at reset ([1:0] stage 1, [3:2] stage 2)
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   EN                  session enable
//   IN_VLD/IN_RDY       input handshake; IN_DR/IN_DI sample data
//   FFT_ED/FFT_START    core enable and START
//   FFT_SHIFT           core scaling code
//   FFT_DR/FFT_DI       core input data
//   FFT_RDY/OVF1/OVF2   core status; FFT_ADDR core result address
//   OUT_VLD/OUT_ADDR    result qualifier and index
//   OUT_SOF/OUT_EOF     first / last result of a frame
//   OUT_OVF             {OVF2, OVF1} captured at EOF
//   BUSY                sequencer is not idle
//
// Build option: define FFT64_AUTOSHIFT_EN to lower each SHIFT stage field
// (saturating at 0) after any session whose results overflowed that stage.
// ---------------------------------------------------------------------------
module fft64_seq_ctrl
   import fft64_ctrl_pkg::*;
#(
   parameter int         NB         = 16,
   parameter logic [3:0] SHIFT_INIT = 4'b0000
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                EN,
   input  logic                IN_VLD,
   output logic                IN_RDY,
   input  logic [NB-1:0]       IN_DR,
   input  logic [NB-1:0]       IN_DI,
   output logic                FFT_ED,
   output logic                FFT_START,
   output logic [3:0]          FFT_SHIFT,
   output logic [NB-1:0]       FFT_DR,
   output logic [NB-1:0]       FFT_DI,
   input  logic                FFT_RDY,
   input  logic                FFT_OVF1,
   input  logic                FFT_OVF2,
   input  logic [FRAME_AW-1:0] FFT_ADDR,
   output logic                OUT_VLD,
   output logic [FRAME_AW-1:0] OUT_ADDR,
   output logic                OUT_SOF,
   output logic                OUT_EOF,
   output logic [1:0]          OUT_OVF,
   output logic                BUSY
);

   state_t              r_state;
   logic [FRAME_AW-1:0] r_cnt;
   logic [1:0]          r_outst;
   logic [3:0]          r_shift;
   logic                r_start;
`ifdef FFT64_AUTOSHIFT_EN
   logic [1:0]          r_ovf_sticky;
`endif

   logic          w_in_rdy;
   logic          w_fft_ed;
   logic [NB-1:0] w_fft_dr;
   logic [NB-1:0] w_fft_di;
   logic          w_acc;
   logic          w_frame_done;
   logic          w_eof;
   logic          w_open;
   logic [1:0]    w_outst_nxt;
   logic          w_pend;

   // Core-side drive, decoded from state; the input path is combinational.
   always_comb begin
      w_in_rdy = 1'b0;
      w_fft_ed = 1'b0;
      w_fft_dr = '0;
      w_fft_di = '0;
      case (r_state)
         ARM: begin
            w_fft_ed = 1'b1;
         end
         STREAM: begin
            // With EN low at a frame boundary no new frame may start; this
            // single cycle precedes the move to FLUSH.
            w_in_rdy = ~(~EN & (r_cnt == '0));
            w_fft_ed = IN_VLD & w_in_rdy;
            w_fft_dr = IN_DR;
            w_fft_di = IN_DI;
         end
         FLUSH: begin
            w_fft_ed = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign w_acc        = IN_VLD & w_in_rdy;
   assign w_frame_done = w_acc & (r_cnt == FRAME_AW'(FRAME_LEN - 1));

   // Frames in flight: +1 when a frame's last sample enters, -1 at its EOF.
   always_comb begin
      case ({w_frame_done, w_eof})
         2'b10:   w_outst_nxt = r_outst + 2'd1;
         2'b01:   w_outst_nxt = r_outst - 2'd1;
         default: w_outst_nxt = r_outst;
      endcase
   end

   assign w_pend = (w_outst_nxt != 2'd0);

   fft64_out_tracker u_trk (
      .i_clk  (CLK),
      .i_rst  (RST),
      .i_ed   (w_fft_ed),
      .i_rdy  (FFT_RDY),
      .i_pend (w_pend),
      .i_ovf1 (FFT_OVF1),
      .i_ovf2 (FFT_OVF2),
      .i_addr (FFT_ADDR),
      .o_vld  (OUT_VLD),
      .o_addr (OUT_ADDR),
      .o_sof  (OUT_SOF),
      .o_eof  (w_eof),
      .o_ovf  (OUT_OVF),
      .o_open (w_open)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_outst <= 2'd0;
         r_shift <= SHIFT_INIT;
         r_start <= 1'b0;
`ifdef FFT64_AUTOSHIFT_EN
         r_ovf_sticky <= 2'b00;
`endif
      end else begin
         r_start <= 1'b0;
         r_outst <= w_outst_nxt;
         if (w_acc) begin
            r_cnt <= r_cnt + 1'b1;
         end
`ifdef FFT64_AUTOSHIFT_EN
         if (w_eof) begin
            r_ovf_sticky <= r_ovf_sticky | {FFT_OVF2, FFT_OVF1};
         end
`endif
         case (r_state)
            IDLE: begin
               if (EN) begin
                  r_state <= ARM;
                  r_start <= 1'b1;
`ifdef FFT64_AUTOSHIFT_EN
                  r_ovf_sticky <= 2'b00;
`endif
               end
            end
            ARM: begin
               r_state <= STREAM;
            end
            STREAM: begin
               // Close only at a frame boundary: either the last sample of
               // the frame is entering now, or no frame is in progress.
               if (~EN && (w_frame_done || (r_cnt == '0))) begin
                  r_state <= FLUSH;
               end
            end
            FLUSH: begin
               if ((r_outst == 2'd0) && ~w_open) begin
                  r_state <= IDLE;
`ifdef FFT64_AUTOSHIFT_EN
                  if (r_ovf_sticky[0]) begin
                     r_shift[SHIFT_S1_LSB +: SHIFT_FIELD_W] <=
                        sat_dec2(r_shift[SHIFT_S1_LSB +: SHIFT_FIELD_W]);
                  end
                  if (r_ovf_sticky[1]) begin
                     r_shift[SHIFT_S2_LSB +: SHIFT_FIELD_W] <=
                        sat_dec2(r_shift[SHIFT_S2_LSB +: SHIFT_FIELD_W]);
                  end
`endif
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign IN_RDY    = w_in_rdy;
   assign FFT_ED    = w_fft_ed;
   assign FFT_DR    = w_fft_dr;
   assign FFT_DI    = w_fft_di;
   assign FFT_START = r_start;
   assign FFT_SHIFT = r_shift;
   assign OUT_EOF   = w_eof;
   assign BUSY      = (r_state != IDLE);

endmodule

// File: tb/tb_fft64_seq_ctrl.sv
module tb_fft64_seq_ctrl;
   import fft64_ctrl_pkg::*;

   localparam int         NB      = 16;
   localparam int         LAT     = 70;       // core model latency in ED cycles
   localparam logic [3:0] SH_INIT = 4'b0101;
`ifdef FFT64_AUTOSHIFT_EN
   localparam logic [3:0] SH_AFTER = 4'b0100;
`else
   localparam logic [3:0] SH_AFTER = 4'b0101;
`endif

   logic          CLK, RST, EN, IN_VLD, IN_RDY;
   logic [NB-1:0] IN_DR, IN_DI, FFT_DR, FFT_DI;
   logic          FFT_ED, FFT_START, FFT_RDY, FFT_OVF1, FFT_OVF2;
   logic [3:0]    FFT_SHIFT;
   logic [5:0]    FFT_ADDR, OUT_ADDR;
   logic          OUT_VLD, OUT_SOF, OUT_EOF, BUSY;
   logic [1:0]    OUT_OVF;

   fft64_seq_ctrl #(.NB(NB), .SHIFT_INIT(SH_INIT)) dut (
      .CLK(CLK), .RST(RST), .EN(EN),
      .IN_VLD(IN_VLD), .IN_RDY(IN_RDY), .IN_DR(IN_DR), .IN_DI(IN_DI),
      .FFT_ED(FFT_ED), .FFT_START(FFT_START), .FFT_SHIFT(FFT_SHIFT),
      .FFT_DR(FFT_DR), .FFT_DI(FFT_DI),
      .FFT_RDY(FFT_RDY), .FFT_OVF1(FFT_OVF1), .FFT_OVF2(FFT_OVF2), .FFT_ADDR(FFT_ADDR),
      .OUT_VLD(OUT_VLD), .OUT_ADDR(OUT_ADDR), .OUT_SOF(OUT_SOF), .OUT_EOF(OUT_EOF),
      .OUT_OVF(OUT_OVF), .BUSY(BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Core model: counts ED cycles since START; frame f's RDY comes LAT ED
   // cycles after its last input sample, results follow with ADDR 0..63.
   // OVF1 latches on a full-scale real input and clears with START.
   int          r_edcnt;
   logic        r_ovf1;
   int          w_k;
   logic [31:0] w_atmp;
   always @(posedge CLK) begin
      if (RST || FFT_START) begin
         r_edcnt <= 0;
         r_ovf1  <= 1'b0;
      end else begin
         if (FFT_ED) r_edcnt <= r_edcnt + 1;
         if (FFT_ED && FFT_DR == 16'h7FFF) r_ovf1 <= 1'b1;
      end
   end
   assign w_k      = r_edcnt - 63 - LAT;
   assign FFT_RDY  = FFT_ED && !FFT_START && (w_k >= 0) && ((w_k % 64) == 0);
   assign w_atmp   = r_edcnt - 64 - LAT;
   assign FFT_ADDR = w_atmp[5:0];
   assign FFT_OVF1 = r_ovf1;
   assign FFT_OVF2 = 1'b0;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Scoreboard: 64 expected results are queued when a frame's last sample
   // is accepted and popped as the DUT qualifies results.
   typedef struct packed {logic [5:0] addr; logic sof; logic eof;} exp_t;
   exp_t q[$];
   int m_cnt = 0, m_out = 0, m_out_max = 0;
   int eof_cnt = 0, start_cnt = 0, vld_cnt = 0;

   always @(negedge CLK) begin
      if (RST) begin
         q.delete();
         m_cnt = 0;
         m_out = 0;
      end else begin
         if (FFT_START) start_cnt++;
         if (IN_RDY) chk("stream_passthru", {FFT_ED, FFT_DR, FFT_DI}, {IN_VLD, IN_DR, IN_DI});
         if (IN_VLD && IN_RDY) begin
            if (m_cnt == 63) begin
               for (int j = 0; j < 64; j++) q.push_back('{6'(j), (j == 0), (j == 63)});
               m_out++;
               chk("outstanding_le_max", (m_out <= MAX_OUTSTANDING), 1);
            end
            m_cnt = (m_cnt + 1) % 64;
         end
         if (OUT_VLD) begin
            exp_t e;
            vld_cnt++;
            chk("sb_has_entry", (q.size() != 0), 1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("out_addr_sof_eof", {OUT_ADDR, OUT_SOF, OUT_EOF}, e);
            end
            if (OUT_EOF) begin
               eof_cnt++;
               m_out--;
            end
         end
         if (m_out > m_out_max) m_out_max = m_out;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input int n, input bit toggle, input bit full);
      int sent = 0;
      int guard = 0;
      bit ph = 1'b1;
      while (sent < n && guard < 4000) begin
         IN_VLD = toggle ? ph : 1'b1;
         ph     = ~ph;
         IN_DR  = full ? 16'h7FFF : 16'($urandom_range(1, 32766));
         IN_DI  = full ? 16'h7FFF : 16'($urandom_range(1, 32766));
         @(negedge CLK);
         if (IN_VLD && IN_RDY) sent++;
         tick();
         guard++;
      end
      IN_VLD = 1'b0;
      chk("samples_accepted", sent, n);
   endtask

   task automatic wait_rdy();
      int n = 0;
      @(negedge CLK);
      while (!IN_RDY && n < 10) begin
         @(negedge CLK);
         n++;
      end
      chk("wait_in_rdy", IN_RDY, 1);
      tick();
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge CLK);
      while (BUSY && n < 2000) begin
         @(negedge CLK);
         n++;
      end
      chk("reach_idle", BUSY, 0);
      tick();
   endtask

   task automatic check_reset(input string tag);
      @(posedge CLK);
      @(negedge CLK);
      chk({tag, "_in_rdy"},   IN_RDY, 0);
      chk({tag, "_fft_ed"},   FFT_ED, 0);
      chk({tag, "_start"},    FFT_START, 0);
      chk({tag, "_shift"},    FFT_SHIFT, SH_INIT);
      chk({tag, "_fft_data"}, {FFT_DR, FFT_DI}, 0);
      chk({tag, "_out_q"},    {OUT_VLD, OUT_SOF, OUT_EOF, OUT_ADDR}, 0);
      chk({tag, "_out_ovf"},  OUT_OVF, 0);
      chk({tag, "_busy"},     BUSY, 0);
   endtask

   typedef struct {logic vld; logic [15:0] dr; logic [15:0] di; logic exp_ed;} vec_t;
   vec_t tbl[8];

   int s0, e0, v0, acc;

   initial begin
      tbl[0] = '{1'b1, 16'h0011, 16'h0022, 1'b1};
      tbl[1] = '{1'b0, 16'h1234, 16'h4321, 1'b0};
      tbl[2] = '{1'b1, 16'h7FFE, 16'h8001, 1'b1};
      tbl[3] = '{1'b1, 16'h0001, 16'hFFFF, 1'b1};
      tbl[4] = '{1'b0, 16'h5555, 16'hAAAA, 1'b0};
      tbl[5] = '{1'b0, 16'h0F0F, 16'hF0F0, 1'b0};
      tbl[6] = '{1'b1, 16'h3C3C, 16'hC3C3, 1'b1};
      tbl[7] = '{1'b0, 16'h00FF, 16'hFF00, 1'b0};

      RST = 1'b1; EN = 1'b0; IN_VLD = 1'b1; IN_DR = 16'h1357; IN_DI = 16'h2468;
      check_reset("por");
      tick();
      RST = 1'b0; IN_VLD = 1'b0;
      tick();

      // Single frame session with the START/IN_RDY timing.
      s0 = start_cnt; e0 = eof_cnt; v0 = vld_cnt;
      EN = 1'b1;
      @(negedge CLK);
      chk("t1_start_at_t", FFT_START, 0);
      tick();
      @(negedge CLK);
      chk("t1_arm_drive", {FFT_START, FFT_ED, IN_RDY, BUSY}, 4'b1101);
      tick();
      @(negedge CLK);
      chk("t1_stream_drive", {FFT_START, IN_RDY}, 2'b01);
      tick();
      send(64, 1'b0, 1'b0);
      EN = 1'b0;
      wait_idle();
      chk("t1_start_pulses", start_cnt - s0, 1);
      chk("t1_eofs", eof_cnt - e0, 1);
      chk("t1_results", vld_cnt - v0, 64);
      chk("t1_sb_empty", q.size(), 0);
      chk("t1_ovf", OUT_OVF, 2'b00);
      chk("t1_shift", FFT_SHIFT, SH_INIT);

      // Three back-to-back frames, table-driven start then 1010 valid.
      s0 = start_cnt; e0 = eof_cnt; m_out_max = 0;
      EN = 1'b1;
      wait_rdy();
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         IN_VLD = tbl[i].vld; IN_DR = tbl[i].dr; IN_DI = tbl[i].di;
         @(negedge CLK);
         chk("t2_tbl_rdy", IN_RDY, 1);
         chk("t2_tbl_ed", FFT_ED, tbl[i].exp_ed);
         chk("t2_tbl_data", {FFT_DR, FFT_DI}, {tbl[i].dr, tbl[i].di});
         if (IN_VLD && IN_RDY) acc++;
         tick();
      end
      IN_VLD = 1'b0;
      send(192 - acc, 1'b1, 1'b0);
      EN = 1'b0;
      wait_idle();
      chk("t2_eofs", eof_cnt - e0, 3);
      chk("t2_start_pulses", start_cnt - s0, 1);
      chk("t2_outst_max", (m_out_max <= MAX_OUTSTANDING), 1);
      chk("t2_sb_empty", q.size(), 0);

      // EN dropped mid-frame: the frame completes, then FLUSH zero-fills.
      e0 = eof_cnt;
      EN = 1'b1;
      wait_rdy();
      send(64, 1'b0, 1'b0);
      send(20, 1'b0, 1'b0);
      EN = 1'b0;
      send(44, 1'b0, 1'b0);
      IN_VLD = 1'b1; IN_DR = 16'h0ABC; IN_DI = 16'h0DEF;
      @(negedge CLK);
      chk("t3_flush_entry", {IN_RDY, BUSY}, 2'b01);
      begin
         int n = 0;
         while (BUSY && n < 2000) begin
            chk("t3_flush_drive", {FFT_ED, FFT_DR, FFT_DI}, {1'b1, 32'h0});
            tick();
            IN_DR = 16'($urandom_range(1, 65535));
            @(negedge CLK);
            n++;
         end
      end
      IN_VLD = 1'b0;
      chk("t3_idle", BUSY, 0);
      chk("t3_eofs", eof_cnt - e0, 2);
      tick();

      // Full-scale frame forcing stage-1 overflow.
      EN = 1'b1;
      wait_rdy();
      send(64, 1'b0, 1'b1);
      EN = 1'b0;
      wait_idle();
      chk("t4_ovf_at_eof", OUT_OVF, 2'b01);
      chk("t4_shift_idle", FFT_SHIFT, SH_AFTER);

      // Next session uses the new code; RST mid-STREAM with 2 frames in flight.
      EN = 1'b1;
      tick();
      @(negedge CLK);
      chk("t5_arm_shift", {FFT_START, FFT_SHIFT}, {1'b1, SH_AFTER});
      tick();
      send(138, 1'b0, 1'b0);
      chk("t5_outstanding", m_out, 2);
      RST = 1'b1; EN = 1'b0; IN_VLD = 1'b1; IN_DR = 16'h1234; IN_DI = 16'h5678;
      check_reset("t5_rst");
      tick();
      RST = 1'b0; IN_VLD = 1'b0;
      tick();
      s0 = start_cnt; e0 = eof_cnt; v0 = vld_cnt;
      EN = 1'b1;
      wait_rdy();
      send(64, 1'b0, 1'b0);
      EN = 1'b0;
      wait_idle();
      chk("t5_start_pulses", start_cnt - s0, 1);
      chk("t5_eofs", eof_cnt - e0, 1);
      chk("t5_results", vld_cnt - v0, 64);
      chk("t5_sb_empty", q.size(), 0);
      chk("t5_ovf", OUT_OVF, 2'b00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fft64_seq_ctrl.md
# fft64_seq_ctrl

Sequencer for the 64-point pipelined FFT core (`USFFT64_2B`). It converts a valid/ready sample stream into the core's ED/START/DR/DI protocol and issues the START pulse that opens each session. It tracks in-flight frames, drains the pipeline at session end, and re-frames the core's RDY/ADDR output into a qualified stream with SOF/EOF and per-frame overflow status. It sits between the upstream sample source and the FFT core; the core's output data goes straight to the consumer, and this block supplies only the qualifiers.

## Interface
Parameters:
- NB, 16, input sample width; matches the core's nb.
- SHIFT_INIT, 4'b0000, SHIFT code loaded at reset. Bits 1:0 are stage 1, bits 3:2 are stage 2.

Ports:
- CLK  in  1  single clock.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  session enable. Rising level opens a session; low at a frame boundary closes it.
- IN_VLD  in  1  input sample valid.
- IN_RDY  out  1  input sample ready.
- IN_DR, IN_DI  in  NB  input sample, real and imaginary.
- FFT_ED  out  1  core enable.
- FFT_START  out  1  core START.
- FFT_SHIFT  out  4  core SHIFT.
- FFT_DR, FFT_DI  out  NB  core input data.
- FFT_RDY, FFT_OVF1, FFT_OVF2  in  1  core status.
- FFT_ADDR  in  6  core result address.
- OUT_VLD  out  1  core DOR/DOI valid this cycle.
- OUT_ADDR  out  6  result index.
- OUT_SOF, OUT_EOF  out  1  first and last result of a frame.
- OUT_OVF  out  2  {OVF2, OVF1} sampled at EOF.
- BUSY  out  1  state is not IDLE.

## Operation
- States:
  - IDLE → ARM when EN=1.
  - ARM (1 cycle) → STREAM.
  - STREAM → FLUSH when EN=0 and the sample counter is 0.
  - FLUSH → IDLE when outstanding=0 and no output window is open.
- ARM drives:
  - FFT_START=1, FFT_ED=1, IN_RDY=0.
  - The START falling edge resets the core's overflow flags.
- STREAM drives:
  - IN_RDY=1.
  - FFT_ED = IN_VLD. The whole core stalls while the source stalls.
  - FFT_DR/DI = IN_DR/DI, combinational.
  - A 6-bit sample counter increments on each accepted sample.
- Closing a session:
  - An EN drop mid-frame is ignored until the 64th sample of that frame is accepted.
  - A complete frame is never truncated.
- FLUSH drives:
  - IN_RDY=0, FFT_ED=1, FFT_DR/DI=0.
  - Continues until all outstanding frames have left the core.
- Outstanding-frame counter (2 bits):
  - +1 on acceptance of sample 63.
  - −1 on the cycle OUT_EOF is generated.
  - Simultaneous +1/−1 leaves it unchanged.
  - Increment at 3 is impossible by construction; the bench asserts this.
- Output window:
  - Opens on the first FFT_ED=1 cycle after FFT_RDY=1 is seen with FFT_ED=1.
  - Spans 64 ED cycles.
  - OUT_VLD = window open AND FFT_ED.
  - OUT_ADDR = FFT_ADDR.
  - OUT_SOF on window cycle 0; OUT_EOF on window cycle 63.
  - OUT_OVF is captured from FFT_OVF2/OVF1 at EOF and held until the next EOF.
- FFT_SHIFT is constant within a session. It is updated only in IDLE.
- RST in any state:
  - Goes to IDLE and clears all counters and the window.
  - In-flight core frames are abandoned; the core is reset by the same RST.

## Timing
- Reset values:
  - IN_RDY=0, FFT_ED=0, FFT_START=0.
  - FFT_SHIFT=SHIFT_INIT, FFT_DR/DI=0.
  - OUT_VLD/SOF/EOF=0, OUT_ADDR=0, OUT_OVF=0, BUSY=0.
- Input path (IN→FFT_*) is zero-latency combinational.
- Output qualifiers (OUT_*) are combinational from registered window state and FFT_ED, so they align with the core's DOR/DOI.
- EN=1 in IDLE at cycle t gives FFT_START=1 at t+1 and IN_RDY=1 at t+2.
- A sample is accepted on any cycle with IN_VLD & IN_RDY. Back-to-back frames are accepted with no gap cycle.

## Configuration
- FFT64_AUTOSHIFT_EN defined:
  - A sticky per-session flag ORs every OUT_OVF captured during the session.
  - On FLUSH→IDLE, each stage field whose flag is set is decremented, saturating at 0.
  - The new code applies to the next session.
- FFT64_AUTOSHIFT_EN undefined: FFT_SHIFT stays SHIFT_INIT until RST.

## Structure
- Package fft64_ctrl_pkg holds:
  - the state enum (IDLE, ARM, STREAM, FLUSH),
  - FRAME_LEN=64 and FRAME_AW=6,
  - MAX_OUTSTANDING=3,
  - the SHIFT field offsets.
- One sub-module, fft64_out_tracker, covers:
  - the output-window counter,
  - SOF/EOF/VLD generation,
  - OVF capture.

## Test plan
- EN=1, 64 continuous samples, then EN=0 → one FFT_START pulse; 64 OUT_VLD with OUT_ADDR 0..63; SOF at addr 0, EOF at addr 63; then IDLE with BUSY=0.
- Three back-to-back frames with IN_VLD toggled 1010… → FFT_ED mirrors IN_VLD; outstanding never exceeds 3; exactly 3 EOFs.
- EN=0 at sample 20 of frame 2 → samples 21..63 are still accepted; FLUSH starts after sample 63; FFT_DR/DI=0 throughout FLUSH.
- Full-scale input with SHIFT_INIT=4'b0101 forcing OVF1, macro defined → OUT_OVF=2'b01 at EOF; next session FFT_SHIFT=4'b0100. With the macro undefined, the next session keeps 4'b0101.
- RST asserted mid-STREAM with outstanding=2 → all outputs at reset values on the next cycle; a new EN gives a clean START and the correct frame.
